// File: rtl/counter_responder_pkg.sv
// Shared encodings for the three-channel counter responder: modes, register
// select codes and control register field positions.
package counter_responder_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_SQUARE   = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SEL_CH0  = 2'b00,
    SEL_CH1  = 2'b01,
    SEL_CH2  = 2'b10,
    SEL_CTRL = 2'b11
  } sel_e;

  localparam int NUM_CH      = 3;
  localparam int CTRL_W      = 10;
  localparam int CTRL_EN_LSB = 0;
  localparam int CTRL_MODE_LSB = 4;
  localparam int CTRL_MODE_W = 2;
  // Bit 3 is unimplemented and always reads back as zero.
  localparam logic [CTRL_W-1:0] CTRL_MASK = 10'h3F7;

  function automatic mode_e ctrl_mode(input logic [CTRL_W-1:0] ctrl, input int ch);
    logic [CTRL_MODE_W-1:0] raw;
    raw = ctrl[CTRL_MODE_LSB + CTRL_MODE_W*ch +: CTRL_MODE_W];
    return mode_e'(raw);
  endfunction

  function automatic logic ctrl_en(input logic [CTRL_W-1:0] ctrl, input int ch);
    return ctrl[CTRL_EN_LSB + ch];
  endfunction

endpackage

// File: rtl/counter_responder_channel.sv
// One down-counting channel: reload/count registers plus the terminal output
// behaviour for one-shot, periodic and square-wave modes.
module counter_channel
  import counter_responder_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             tick_i,
  input  logic             en_i,
  input  mode_e            mode_i,
  output logic [CNT_W-1:0] count_o,
  output logic             out_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             out_q, out_d;

  // Next-state: a write beats any terminal event; a zero count is idle.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    out_d    = out_q;
    // Periodic pulses last one clk cycle regardless of the tick rate.
    if (mode_i == MODE_PERIODIC) begin
      out_d = 1'b0;
    end else begin
      out_d = out_q;
    end
    if (load_i) begin
      count_d  = load_val_i;
      reload_d = load_val_i;
      out_d    = 1'b0;
    end else if (tick_i && en_i && (count_q != CNT_ZERO)) begin
      if (count_q == CNT_ONE) begin
        case (mode_i)
          MODE_PERIODIC: begin
            count_d = reload_q;
            out_d   = 1'b1;
          end
          MODE_SQUARE: begin
            count_d = reload_q;
            out_d   = ~out_q;
          end
          MODE_ONESHOT, MODE_RSVD: begin
            count_d = CNT_ZERO;
            out_d   = 1'b1;
          end
          default: begin
            count_d = CNT_ZERO;
            out_d   = 1'b1;
          end
        endcase
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      out_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      out_q    <= out_d;
    end
  end

  assign count_o = count_q;
  assign out_o   = out_q;

endmodule

// File: rtl/counter_responder.sv
// Three-channel bus-programmable counter/timer with shared prescaler,
// control register and registered readback.
module counter_responder
  import counter_responder_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             counter_we,
  input  logic [1:0]       counter_sel,
  input  logic [CNT_W-1:0] counter_val,
  output logic [CNT_W-1:0] counter_out,
  output logic             counter0_out,
  output logic             counter1_out,
  output logic             counter2_out
);

  localparam int PRESC_W = 16;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_s;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   counter_out_q, counter_out_d;
  logic [CNT_W-1:0]   ch_count_s [NUM_CH];
  logic [NUM_CH-1:0]  ch_out_s;

  assign tick_s = (presc_q == PRESC_LAST);

  // Free-running prescaler; bus traffic never disturbs its phase.
  always_comb begin
    if (tick_s) begin
      presc_d = {PRESC_W{1'b0}};
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // Control register update.
  always_comb begin
    if (counter_we && (counter_sel == SEL_CTRL)) begin
      ctrl_d = counter_val[CTRL_W-1:0] & CTRL_MASK;
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Readback mux samples pre-edge register values, giving one cycle latency.
  always_comb begin
    counter_out_d = {CNT_W{1'b0}};
    case (sel_e'(counter_sel))
      SEL_CH0:  counter_out_d = ch_count_s[0];
      SEL_CH1:  counter_out_d = ch_count_s[1];
      SEL_CH2:  counter_out_d = ch_count_s[2];
      SEL_CTRL: counter_out_d = CNT_W'(ctrl_q);
      default:  counter_out_d = {CNT_W{1'b0}};
    endcase
  end

  // Top-level state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q       <= {PRESC_W{1'b0}};
      ctrl_q        <= {CTRL_W{1'b0}};
      counter_out_q <= {CNT_W{1'b0}};
    end else begin
      presc_q       <= presc_d;
      ctrl_q        <= ctrl_d;
      counter_out_q <= counter_out_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_channel #(
      .CNT_W(CNT_W)
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst),
      .load_i    (counter_we && (counter_sel == 2'(i))),
      .load_val_i(counter_val),
      .tick_i    (tick_s),
      .en_i      (ctrl_en(ctrl_q, i)),
      .mode_i    (ctrl_mode(ctrl_q, i)),
      .count_o   (ch_count_s[i]),
      .out_o     (ch_out_s[i])
    );
  end

  assign counter_out  = counter_out_q;
  assign counter0_out = ch_out_s[0];
  assign counter1_out = ch_out_s[1];
  assign counter2_out = ch_out_s[2];

endmodule

// File: tb/tb_counter_responder.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// randomized traffic against a behavioural model, and a DIV=4 instance.
module tb_counter_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, we4 = 1'b0;
  logic [1:0]  sel = 2'd0, sel4 = 2'd0;
  logic [31:0] val = 32'd0, val4 = 32'd0;
  logic [31:0] rb, rb4;
  logic        o0, o1, o2, p0, p1, p2;
  int          n_chk = 0;
  int          n_err = 0;
  int          edge_cnt = 0;

  always #5 clk = ~clk;

  counter_responder #(.CNT_W(32), .DIV(1)) dut (
    .clk(clk), .rst(rst), .counter_we(we), .counter_sel(sel), .counter_val(val),
    .counter_out(rb), .counter0_out(o0), .counter1_out(o1), .counter2_out(o2));

  counter_responder #(.CNT_W(32), .DIV(4)) dut4 (
    .clk(clk), .rst(rst), .counter_we(we4), .counter_sel(sel4), .counter_val(val4),
    .counter_out(rb4), .counter0_out(p0), .counter1_out(p1), .counter2_out(p2));

  // Clock edges since reset release; the DIV=4 prescaler ticks on multiples of 4.
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit w, input logic [1:0] s, input logic [31:0] v);
    we = w; sel = s; val = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc4(input bit w, input logic [1:0] s, input logic [31:0] v);
    we4 = w; sel4 = s; val4 = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Behavioural model of the DIV=1 instance: per-channel numbers, one step per edge.
  int unsigned m_cnt [3];
  int unsigned m_rel [3];
  bit          m_out [3];
  int unsigned m_ctrl, m_rb;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_out[i] = 1'b0;
    end
    m_ctrl = 0; m_rb = 0;
  endtask

  task automatic model_step(input bit w, input int s, input int unsigned v);
    int unsigned mode;
    m_rb = (s == 3) ? m_ctrl : m_cnt[s];
    for (int i = 0; i < 3; i++) begin
      mode = (m_ctrl >> (4 + 2*i)) & 3;
      if (mode == 1) m_out[i] = 1'b0;
      if (w && s == i) begin
        m_cnt[i] = v; m_rel[i] = v; m_out[i] = 1'b0;
      end else if (((m_ctrl >> i) & 1) == 1 && m_cnt[i] != 0) begin
        if (m_cnt[i] == 1) begin
          case (mode)
            1: begin m_cnt[i] = m_rel[i]; m_out[i] = 1'b1; end
            2: begin m_cnt[i] = m_rel[i]; m_out[i] = !m_out[i]; end
            default: begin m_cnt[i] = 0; m_out[i] = 1'b1; end
          endcase
        end else begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end
    end
    if (w && s == 3) m_ctrl = v & 32'h3F7;
  endtask

  typedef struct {
    bit          w;
    logic [1:0]  s;
    logic [31:0] v;
    logic [31:0] rb;
    logic [2:0]  outs;
  } vec_t;

  vec_t tbl [23];

  initial begin
    int n, kt, t1, m, exp_lat;
    bit w;
    logic [1:0] s;
    logic [31:0] v;

    // Periodic ch1, collision, square ch2, then disabled ch1 holding.
    tbl[0]  = '{1'b1, 2'd1, 32'd3,     32'd0,     3'b000};
    tbl[1]  = '{1'b1, 2'd3, 32'h42,    32'd0,     3'b000};
    tbl[2]  = '{1'b0, 2'd1, 32'd0,     32'd3,     3'b000};
    tbl[3]  = '{1'b0, 2'd1, 32'd0,     32'd2,     3'b000};
    tbl[4]  = '{1'b0, 2'd1, 32'd0,     32'd1,     3'b010};
    tbl[5]  = '{1'b0, 2'd1, 32'd0,     32'd3,     3'b000};
    tbl[6]  = '{1'b0, 2'd1, 32'd0,     32'd2,     3'b000};
    tbl[7]  = '{1'b0, 2'd1, 32'd0,     32'd1,     3'b010};
    tbl[8]  = '{1'b0, 2'd1, 32'd0,     32'd3,     3'b000};
    tbl[9]  = '{1'b0, 2'd1, 32'd0,     32'd2,     3'b000};
    tbl[10] = '{1'b1, 2'd1, 32'd7,     32'd1,     3'b000};
    tbl[11] = '{1'b0, 2'd1, 32'd0,     32'd7,     3'b000};
    tbl[12] = '{1'b1, 2'd2, 32'd4,     32'd0,     3'b000};
    tbl[13] = '{1'b1, 2'd3, 32'h204,   32'h42,    3'b000};
    tbl[14] = '{1'b0, 2'd2, 32'd0,     32'd4,     3'b000};
    tbl[15] = '{1'b0, 2'd2, 32'd0,     32'd3,     3'b000};
    tbl[16] = '{1'b0, 2'd2, 32'd0,     32'd2,     3'b000};
    tbl[17] = '{1'b0, 2'd2, 32'd0,     32'd1,     3'b100};
    tbl[18] = '{1'b0, 2'd2, 32'd0,     32'd4,     3'b100};
    tbl[19] = '{1'b0, 2'd2, 32'd0,     32'd3,     3'b100};
    tbl[20] = '{1'b0, 2'd2, 32'd0,     32'd2,     3'b100};
    tbl[21] = '{1'b0, 2'd2, 32'd0,     32'd1,     3'b000};
    tbl[22] = '{1'b0, 2'd1, 32'd0,     32'd4,     3'b000};

    // Reset state.
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_readback", rb, 32'd0);
    chk("reset_outs", {29'd0, o2, o1, o0}, 32'd0);
    chk("reset_readback_div4", rb4, 32'd0);
    chk("reset_outs_div4", {29'd0, p2, p1, p0}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].w, tbl[i].s, tbl[i].v);
      chk($sformatf("vec%0d_readback", i), rb, tbl[i].rb);
      chk($sformatf("vec%0d_outs", i), {29'd0, o2, o1, o0}, {29'd0, tbl[i].outs});
    end

    // One-shot: ch0=5, control=0x001 at edge T; output rises after T+5.
    cyc(1'b1, 2'd0, 32'd5);
    cyc(1'b1, 2'd3, 32'h001);
    for (int k = 1; k <= 7; k++) begin
      cyc(1'b0, 2'd0, 32'd0);
      chk($sformatf("oneshot_t%0d", k), {31'd0, o0}, (k >= 5) ? 32'd1 : 32'd0);
      if (k == 6) chk("oneshot_count_zero", rb, 32'd0);
    end
    cyc(1'b1, 2'd0, 32'd2);
    chk("oneshot_rewrite_low", {31'd0, o0}, 32'd0);

    // Reset while ch0 is counting at 3.
    cyc(1'b1, 2'd0, 32'd5);
    cyc(1'b0, 2'd0, 32'd0);
    cyc(1'b0, 2'd0, 32'd0);
    chk("midcount_before_reset", rb, 32'd4);
    rst = 1'b0;
    #1;
    chk("midcount_async_readback", rb, 32'd0);
    chk("midcount_async_outs", {29'd0, o2, o1, o0}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 2'd0, 32'd0);
      chk("after_reset_count", rb, 32'd0);
    end
    cyc(1'b0, 2'd3, 32'd0);
    chk("after_reset_ctrl", rb, 32'd0);
    cyc(1'b1, 2'd3, 32'h001);
    cyc(1'b0, 2'd0, 32'd0);
    cyc(1'b0, 2'd0, 32'd0);
    chk("after_reset_no_count", rb, 32'd0);
    chk("after_reset_out0", {31'd0, o0}, 32'd0);

    // Randomized traffic against the model.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 400; k++) begin
      w = ($urandom % 3) == 0;
      s = 2'($urandom % 4);
      v = (s == 2'd3) ? ($urandom & 32'h3FF) : 32'($urandom_range(0, 6));
      cyc(w, s, v);
      model_step(w, int'(s), v);
      chk($sformatf("rand%0d_readback", k), rb, m_rb);
      chk($sformatf("rand%0d_outs", k), {29'd0, o2, o1, o0},
          {29'd0, m_out[2], m_out[1], m_out[0]});
    end
    we = 1'b0;

    // DIV=4: one-shot ch0=2 fires on the second tick after enable.
    cyc4(1'b1, 2'd0, 32'd2);
    cyc4(1'b1, 2'd3, 32'h001);
    kt = edge_cnt;
    t1 = (kt / 4 + 1) * 4;
    exp_lat = t1 + 4 - kt;
    n = 0;
    while (!p0 && n < 40) begin
      cyc4(1'b0, 2'd0, 32'd0);
      n++;
    end
    chk("div4_oneshot_latency", n, exp_lat);
    chk("div4_latency_window", (n >= 5 && n <= 8) ? 32'd1 : 32'd0, 32'd1);

    // DIV=4: disabling mid-count freezes the count.
    cyc4(1'b1, 2'd0, 32'd8);
    m = 8;
    repeat (6) begin
      cyc4(1'b0, 2'd0, 32'd0);
      if (edge_cnt % 4 == 0) m--;
    end
    cyc4(1'b1, 2'd3, 32'h000);
    if (edge_cnt % 4 == 0) m--;
    repeat (12) cyc4(1'b0, 2'd0, 32'd0);
    cyc4(1'b0, 2'd0, 32'd0);
    chk("div4_frozen_count", rb4, m);
    chk("div4_frozen_out0", {31'd0, p0}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
